mux_scan_ctrl: RTL and testbench

//  Sequential scanner for the mux4in stage: drives its select lines and samples its single-bit output.
//  On a start pulse it walks sel through 0..N_IN-1 and captures the mux output for each channel.
//  It then presents the reconstructed N_IN-bit input word with a one-cycle done pulse.

---
 rtl/mux_scan_if.sv | 47 ++++
 rtl/mux_scan_ctrl.sv | 132 +++++++++++++
 tb/tb_mux_scan_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/mux_scan_if.sv
// mux_scan_if -- signal bundle between the mux scanner and the block that
// owns the scanned mux.
//
// Parameters
//   N_IN   number of mux inputs scanned; SEL_W = $clog2(N_IN)
//
// Signals
//   start    request a scan              (into the scanner)
//   mux_out  output of the scanned mux   (into the scanner)
//   sel      mux select                  (from the scanner)
//   busy     scan in progress            (from the scanner)
//   done     one-cycle word-valid pulse  (from the scanner)
//   word     reconstructed mux inputs    (from the scanner)
//
// Modports
//   master   scanner side
//   slave    environment side (mux plus requester)
interface mux_scan_if #(
    parameter int N_IN = 4
);
    localparam int SEL_W = $clog2(N_IN);

    logic             start;
    logic             mux_out;
    logic [SEL_W-1:0] sel;
    logic             busy;
    logic             done;
    logic [N_IN-1:0]  word;

    modport master (
        input  start,
        input  mux_out,
        output sel,
        output busy,
        output done,
        output word
    );

    modport slave (
        output start,
        output mux_out,
        input  sel,
        input  busy,
        input  done,
        input  word
    );
endinterface

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl -- sequential scanner for an N_IN:1 mux.
//
// On a start request it walks sel through 0..N_IN-1. For each channel it
// waits DWELL settle cycles and then samples mux_out for one cycle. After the
// last channel it publishes the reconstructed N_IN-bit word together with a
// one-cycle done pulse. All outputs are registered.
//
// Parameters
//   N_IN   number of mux inputs (>=2, power of two)
//   DWELL  settle cycles per channel before sampling (>=1)
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mux_scan_if.master: start, mux_out in; sel, busy, done, word out
//
// Optional feature
//   MUX_SCAN_AUTO_EN
//     When this macro is defined, a start seen in DONE launches the next scan
//     immediately, so back-to-back scans have no IDLE cycle between them.
//     When it is undefined, DONE always returns to IDLE.
module mux_scan_ctrl #(
    parameter int N_IN  = 4,
    parameter int DWELL = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    mux_scan_if.master    bus
);
    localparam int SEL_W = $clog2(N_IN);
    // The counter climbs to at most DWELL, because it is cleared on every
    // SETTLE entry.
    localparam int CNT_W = $clog2(DWELL + 1);

    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_IN - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    state_t           state_reg;
    logic [SEL_W-1:0] sel_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [N_IN-1:0]  cap_reg;
    logic [N_IN-1:0]  cap_next;
    logic [N_IN-1:0]  word_reg;
    logic             busy_reg;
    logic             done_reg;

    // The capture register with the current sample merged in. On the final
    // SAMPLE this lets word take the last bit on the same edge.
    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_cap
            assign cap_next[gi] = (state_reg == ST_SAMPLE && sel_reg == SEL_W'(gi))
                                  ? bus.mux_out : cap_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            sel_reg   <= '0;
            cnt_reg   <= '0;
            cap_reg   <= '0;
            word_reg  <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_reg <= ST_SETTLE;
                        sel_reg   <= '0;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                    end
                end

                ST_SETTLE: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == CNT_LAST) begin
                        state_reg <= ST_SAMPLE;
                    end
                end

                ST_SAMPLE: begin
                    cap_reg <= cap_next;
                    if (sel_reg == SEL_LAST) begin
                        state_reg <= ST_DONE;
                        word_reg  <= cap_next;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        sel_reg   <= '0;
                    end else begin
                        state_reg <= ST_SETTLE;
                        sel_reg   <= sel_reg + 1'b1;
                        cnt_reg   <= '0;
                    end
                end

                ST_DONE: begin
`ifdef MUX_SCAN_AUTO_EN
                    if (bus.start) begin
                        state_reg <= ST_SETTLE;
                        sel_reg   <= '0;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                    end else begin
                        state_reg <= ST_IDLE;
                    end
`else
                    state_reg <= ST_IDLE;
`endif
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.sel  = sel_reg;
    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.word = word_reg;
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl -- self-checking bench for mux_scan_ctrl.
// Two instances are built, with DWELL=1 and DWELL=3. Each one scans a
// behavioural 4:1 mux driven from in_v. The driver plans every scan from the
// timing rules: the per-cycle sel/busy timeline, the done cycle and the
// captured word. A per-instance monitor compares the DUT against that plan on
// every falling edge.
module tb_mux_scan_ctrl;
    localparam int MAXC = 4000;

    typedef struct {
        int         cyc;
        logic [3:0] w;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_v [2];
    logic [3:0] in_v [2];
    logic [3:0] exp_word [2];
    bit         mon_en = 1'b0;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    int         exp_sel [2][MAXC];
    int         exp_busy [2][MAXC];
    exp_t       exp_q [2][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            localparam int DW = (gi == 0) ? 1 : 3;
            mux_scan_if #(.N_IN(4)) bus ();
            assign bus.start   = start_v[gi];
            assign bus.mux_out = in_v[gi][bus.sel];

            mux_scan_ctrl #(.N_IN(4), .DWELL(DW)) dut (
                .clk   (clk),
                .rst_n (rst_n),
                .bus   (bus.master)
            );

            always @(negedge clk) begin
                if (mon_en && rst_n && cyc < MAXC) begin
                    bit exp_d;
                    exp_d = (exp_q[gi].size() > 0) && (exp_q[gi][0].cyc == cyc);
                    chk("sel", gi, int'(bus.sel), exp_sel[gi][cyc]);
                    chk("busy", gi, int'(bus.busy), exp_busy[gi][cyc]);
                    chk("done", gi, int'(bus.done), int'(exp_d));
                    if (exp_d) begin
                        exp_word[gi] = exp_q[gi][0].w;
                        void'(exp_q[gi].pop_front());
                    end
                    chk("word", gi, int'(bus.word), int'(exp_word[gi]));
                    $display("cyc %0d dut%0d sel=%0d busy=%0b done=%0b word=%b",
                             cyc, gi, bus.sel, bus.busy, bus.done, bus.word);
                end
            end
        end
    endgenerate

    task automatic chk(input string name, input int g, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cyc %0d: got %0d expected %0d", name, g, cyc, act, exp);
        end
    endtask

    function automatic int dwell_of(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    function automatic int len_of(input int g);
        return 4 * (dwell_of(g) + 1);
    endfunction

    // Plans one scan whose start is taken at edge e0. Channel k is sampled at
    // edge e0+(k+1)*(DWELL+1). An input change made at offset chg is visible
    // to every sampling edge strictly after e0+chg.
    function automatic void plan(input int g, input int e0, input logic [3:0] a,
                                 input logic [3:0] b, input int chg);
        int         d = dwell_of(g);
        int         l = len_of(g);
        logic [3:0] w;
        exp_t       e;
        for (int j = 0; j < l; j++) begin
            if (e0 + j < MAXC) begin
                exp_sel[g][e0 + j]  = j / (d + 1);
                exp_busy[g][e0 + j] = 1;
            end
        end
        for (int k = 0; k < 4; k++) begin
            w[k] = (((k + 1) * (d + 1)) > chg) ? b[k] : a[k];
        end
        e.cyc = e0 + l;
        e.w   = w;
        exp_q[g].push_back(e);
    endfunction

    // A single scan. The inputs switch from a to b at offset chg. A spurious
    // start is pulsed at offset poke (-1 means no pulse).
    task automatic scan(input int g, input logic [3:0] a, input logic [3:0] b,
                        input int chg, input int poke);
        int e0;
        int off;
        @(negedge clk);
        e0 = cyc + 1;
        plan(g, e0, a, b, chg);
        start_v[g] = 1'b1;
        in_v[g]    = a;
        while (cyc < e0 + len_of(g)) begin
            @(negedge clk);
            off = cyc - e0;
            if (off == chg) in_v[g] = b;
            start_v[g] = (off == poke);
        end
        @(negedge clk);
        start_v[g] = 1'b0;
    endtask

    initial begin
        #400000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        int e0;
        int p;
        int g;
        int l;
        int n;
        int poke_done;
        start_v[0] = 1'b0; start_v[1] = 1'b0;
        in_v[0] = 4'b0; in_v[1] = 4'b0;
        exp_word[0] = 4'b0; exp_word[1] = 4'b0;

        // Reset values while rst_n is held low.
        repeat (3) @(negedge clk);
        chk("rst_sel", 0, int'(g_dut[0].bus.sel), 0);
        chk("rst_busy", 0, int'(g_dut[0].bus.busy), 0);
        chk("rst_done", 1, int'(g_dut[1].bus.done), 0);
        chk("rst_word", 1, int'(g_dut[1].bus.word), 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        // Directed scans: a basic pattern, a spurious start mid-scan, and an
        // input change right after bit 0 is sampled.
        scan(0, 4'b1010, 4'b1010, 1000, -1);
        scan(1, 4'b0110, 4'b0110, 1000, -1);
        scan(0, 4'b1100, 4'b1100, 1000, 3);
        scan(1, 4'b1001, 4'b1001, 1000, 5);
        scan(0, 4'b0000, 4'b1111, 2, -1);
        scan(1, 4'b0001, 4'b1111, 4, -1);

        // A start pulse during DONE must be ignored when auto-restart is off.
`ifdef MUX_SCAN_AUTO_EN
        poke_done = -1;
`else
        poke_done = len_of(0);
`endif
        scan(0, 4'b0101, 4'b0101, 1000, poke_done);
        repeat (2) @(negedge clk);

        // Randomised scans.
        for (int r = 0; r < 10; r++) begin
            g = int'($urandom_range(0, 1));
            l = len_of(g);
            scan(g, 4'($urandom), 4'($urandom), int'($urandom_range(0, l + 1)),
                 int'($urandom_range(0, l - 1)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Asynchronous reset in the middle of a scan, once sel reaches 2.
        @(negedge clk);
        e0 = cyc + 1;
        plan(0, e0, 4'b0111, 4'b0111, 1000);
        start_v[0] = 1'b1;
        in_v[0]    = 4'b0111;
        @(negedge clk);
        start_v[0] = 1'b0;
        n = 0;
        while (g_dut[0].bus.sel != 2'd2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("reach_sel2", 0, int'(g_dut[0].bus.sel), 2);
        #1;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("mid_rst_sel", 0, int'(g_dut[0].bus.sel), 0);
        chk("mid_rst_busy", 0, int'(g_dut[0].bus.busy), 0);
        chk("mid_rst_done", 0, int'(g_dut[0].bus.done), 0);
        chk("mid_rst_word", 0, int'(g_dut[0].bus.word), 0);
        chk("mid_rst_word", 1, int'(g_dut[1].bus.word), 0);
        for (int gg = 0; gg < 2; gg++) begin
            exp_q[gg].delete();
            exp_word[gg] = 4'b0;
            for (int c = 0; c < MAXC; c++) begin
                exp_sel[gg][c]  = 0;
                exp_busy[gg][c] = 0;
            end
        end
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (3) @(negedge clk);
        scan(0, 4'b1011, 4'b1011, 1000, -1);

        // start held high: three back-to-back scans, then start is dropped.
`ifdef MUX_SCAN_AUTO_EN
        p = len_of(0) + 1;
`else
        p = len_of(0) + 2;
`endif
        @(negedge clk);
        e0 = cyc + 1;
        for (int r = 0; r < 3; r++) plan(0, e0 + r * p, 4'b0011, 4'b0011, 1000);
        start_v[0] = 1'b1;
        in_v[0]    = 4'b0011;
        while (cyc < e0 + 2 * p + len_of(0)) @(negedge clk);
        start_v[0] = 1'b0;
        repeat (6) @(negedge clk);

        chk("queue_empty", 0, exp_q[0].size(), 0);
        chk("queue_empty", 1, exp_q[1].size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
